serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 149 ++++++++++++++
 tb/tb_serial_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder. On an accepted start the operands are
//                captured and added one bit per clock, LSB first. The result
//                (sum and carry-out) is published in a single update when the
//                final bit is produced, accompanied by a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH   operand width in bits (2..32)
//  Ports
//    clk     in   clock, rising-edge active
//    rst_n   in   synchronous active-low reset
//    start   in   add request, only looked at while idle
//    a       in   augend, captured on the accept edge
//    b       in   addend, captured on the accept edge
//    busy    out  high while an addition is in progress or completing
//    done    out  one-cycle pulse, sum/cout valid
//    sum     out  (a+b) mod 2^WIDTH, held until the next result
//    cout    out  carry out of bit WIDTH-1, held until the next result
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT  = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] r_q,      r_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             s_bit;
    logic             carry_nxt;

    // One full-adder slice working on the current LSBs of the shift registers.
    assign s_bit     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign carry_nxt = (a_sh_q[0] & b_sh_q[0]) |
                       (a_sh_q[0] & carry_q)   |
                       (b_sh_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_d     = r_q;
        carry_d = carry_q;
        count_d = count_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = 1'b0;
                    count_d = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = carry_nxt;
                // Result bits enter at the MSB so that after WIDTH shifts the
                // first (LSB) bit has arrived at position 0.
                r_d     = {s_bit, r_q[WIDTH-1:1]};
                if (count_q == LAST_BIT) begin
                    // Publish on this edge, including the bit just produced.
                    // count stays at its last value rather than wrapping.
                    sum_d   = r_d;
                    cout_d  = carry_nxt;
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // exactly with the state they describe.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder. A driver issues
//                additions and queues the expected result and completion
//                cycle; a monitor pops and compares on every done pulse and
//                checks that sum/cout hold between results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int W  = 8;
    localparam int W4 = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic          start4;
    logic [W4-1:0] a4, b4;
    logic          busy4, done4, cout4;
    logic [W4-1:0] sum4;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(W4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] q_sum[$];
    logic         q_cout[$];
    int unsigned  q_cyc[$];

    logic [W-1:0] held_sum  = '0;
    logic         held_cout = 1'b0;
    logic         mon_en    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (done) begin
                if (q_sum.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
                end else begin
                    logic [W-1:0] es;
                    logic         ec;
                    int unsigned  ed;
                    es = q_sum.pop_front();
                    ec = q_cout.pop_front();
                    ed = q_cyc.pop_front();
                    check("sum",          64'(sum),  64'(es));
                    check("cout",         64'(cout), 64'(ec));
                    check("latency_cyc",  64'(cyc),  64'(ed));
                    check("busy_in_done", 64'(busy), 64'd1);
                    held_sum  = es;
                    held_cout = ec;
                end
            end else begin
                check("held_sum",  64'(sum),  64'(held_sum));
                check("held_cout", 64'(cout), 64'(held_cout));
            end
        end
    end

    // ---------------- reference model + driver ----------------
    task automatic push_expected(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned total;
        total = int'(x) + int'(y);
        q_sum.push_back(W'(total % (1 << W)));
        q_cout.push_back(total >= (1 << W));
        q_cyc.push_back(cyc + 1 + W);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
    endtask

    // Leaves the caller one step after the accept edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        wait_idle();
        a = x;
        b = y;
        start = 1'b1;
        push_expected(x, y);
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic run4(input logic [W4-1:0] x, input logic [W4-1:0] y);
        int unsigned c0;
        int          n;
        int unsigned total;
        total = int'(x) + int'(y);
        a4 = x;
        b4 = y;
        start4 = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = W4'($urandom);
        b4 = W4'($urandom);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (done4) break;
            n++;
        end
        check("w4_done_seen", 64'(done4), 64'd1);
        check("w4_latency",   64'(cyc),   64'(c0 + 1 + W4));
        check("w4_sum",       64'(sum4),  64'(total % 16));
        check("w4_cout",      64'(cout4), 64'(total >= 16));
        @(negedge clk);
        check("w4_done_width", 64'(done4), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum",  64'(sum),  64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 3+5: busy spans SHIFT (8 cycles) plus DONE (1 cycle)
        issue(8'd3, 8'd5);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        check("busy_cycles", 64'(n), 64'd9);

        issue(8'd255, 8'd1);
        issue(8'd200, 8'd100);
        repeat (3) @(posedge clk);
        #1;
        issue(8'd0, 8'd0);

        // abort mid-operation at count=4
        issue(8'd77, 8'd99);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q_sum.delete();
        q_cout.delete();
        q_cyc.delete();
        held_sum  = '0;
        held_cout = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum",  64'(sum),  64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        issue(8'd200, 8'd100);

        // randomized pulses with random gaps
        for (int i = 0; i < 20; i++) begin
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            issue(W'($urandom), W'($urandom));
        end

        // start held high, operands changing every cycle
        wait_idle();
        for (int i = 0; i < 45; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            start = 1'b1;
            if (!busy) push_expected(a, b);
            @(posedge clk); #1;
        end
        start = 1'b0;

        n = 0;
        while (q_sum.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", 64'(q_sum.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;

        run4(4'd15, 4'd15);
        run4(4'd9,  4'd4);
        run4(4'(($urandom)), 4'(($urandom)));

        check("final_pending", 64'(q_sum.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
